// File: rtl/serial_frame_deserializer.sv
// Framed serial-to-parallel converter: collects 1..WIDTH bits per frame in either bit order,
// right-justifies them and holds the word behind a valid/ready handshake.
module serial_frame_deserializer #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] framesize,
    input  logic             serial,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] parallel,
    output logic             parallel_valid,
    input  logic             parallel_ready,
    output logic             busy,
    output logic             overrun,
    output logic             size_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] fs_q, fs_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             overrun_q, overrun_d;
    logic             size_err_q, size_err_d;

    logic             take;
    logic             start_req;
    logic [CNT_W-1:0] fs_in;
    logic [CNT_W-1:0] count_inc;

    // MSB-first shifts left so the first bit drifts up to bit fs-1; LSB-first writes bit k-1.
    function automatic logic [WIDTH-1:0] store_bit(input logic [WIDTH-1:0] base,
                                                   input logic             b,
                                                   input logic [CNT_W-1:0] idx);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {base[WIDTH-2:0], b};
        end else begin
            r = base | ({{(WIDTH-1){1'b0}}, b} << idx);
        end
        return r;
    endfunction

    always_comb begin
        take       = enable & serial_valid;
        fs_in      = (framesize > WIDTH_C) ? WIDTH_C : framesize;
        count_inc  = count_q + CNT_W'(1);
        start_req  = 1'b0;
        state_d    = state_q;
        count_d    = count_q;
        fs_d       = fs_q;
        shreg_d    = shreg_q;
        overrun_d  = 1'b0;
        size_err_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            shreg_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    start_req = take;
                end
                SHIFT: begin
                    if (take) begin
                        shreg_d = store_bit(shreg_q, serial, count_q);
                        count_d = count_inc;
                        if (count_inc == fs_q) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (parallel_ready) begin
                        state_d   = IDLE;
                        count_d   = '0;
                        start_req = take;
                    end else if (take) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase

            // A frame starts from a zeroed register; framesize is only sampled here.
            if (start_req) begin
                if (fs_in == '0) begin
                    size_err_d = 1'b1;
                    state_d    = IDLE;
                    count_d    = '0;
                end else begin
                    fs_d    = fs_in;
                    shreg_d = store_bit('0, serial, '0);
                    count_d = CNT_W'(1);
                    state_d = (fs_in == CNT_W'(1)) ? HOLD : SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            fs_q       <= '0;
            shreg_q    <= '0;
            overrun_q  <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fs_q       <= fs_d;
            shreg_q    <= shreg_d;
            overrun_q  <= overrun_d;
            size_err_q <= size_err_d;
        end
    end

    // The word is only presented while held, so a discarded or partial frame never leaks out.
    always_comb begin
        parallel_valid = (state_q == HOLD);
        parallel       = parallel_valid ? shreg_q : '0;
        busy           = (state_q == SHIFT);
        overrun        = overrun_q;
        size_err       = size_err_q;
    end

endmodule
